// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field layout, classification flags and the
// front-end dispatcher state encoding.
package fpu_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int FLAG_W    = 3;
    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_RESULT = 3'd3,
        S_ERR    = 3'd4
    } disp_state_e;

    // Classify a single-precision value as {is_nan, is_inf, is_zero}; zero ignores sign.
    function automatic logic [FLAG_W-1:0] fp32_flags(input logic [FP_W-1:0] z);
        logic [EXP_W-1:0]  exp_s;
        logic [FRAC_W-1:0] frac_s;
        logic [FLAG_W-1:0] flags_s;
        exp_s              = z[FP_W-2:FRAC_W];
        frac_s             = z[FRAC_W-1:0];
        flags_s            = {FLAG_W{1'b0}};
        flags_s[FLAG_NAN]  = (exp_s == EXP_MAX) && (frac_s != {FRAC_W{1'b0}});
        flags_s[FLAG_INF]  = (exp_s == EXP_MAX) && (frac_s == {FRAC_W{1'b0}});
        flags_s[FLAG_ZERO] = (z[FP_W-2:0] == {(FP_W-1){1'b0}});
        return flags_s;
    endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous operand FIFO for FPU front-ends; exposes the next-cycle count so
// callers can register their own full/occupancy indications.
module fpu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count_nxt,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && (count_r != CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt = count_r - CNT_W'(1'b1);
            default: count_nxt = count_r;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            count_r <= count_nxt;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/fpu_add_dispatcher.sv
// Front-end for the single-precision adder: queues operand pairs, runs the
// core start/ack handshake one op at a time and returns classified results.
module fpu_add_dispatcher
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_a,
    input  logic [FP_W-1:0]   in_b,
    output logic              core_start,
    output logic [FP_W-1:0]   core_a,
    output logic [FP_W-1:0]   core_b,
    output logic              core_ack,
    input  logic [FP_W-1:0]   core_z,
    input  logic              core_valid,
    input  logic              core_idle,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP_W-1:0]   res_z,
    output logic [FLAG_W-1:0] res_flags,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    disp_state_e         state_r;
    disp_state_e         state_nxt_s;
    logic [TMR_W-1:0]    timer_r;
    logic                push_s;
    logic                pop_s;
    logic                fifo_empty_s;
    logic [2*FP_W-1:0]   head_s;
    logic [CNT_W-1:0]    count_nxt_s;

    assign push_s = in_valid && in_ready;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*FP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .wr_data   ({in_a, in_b}),
        .rd_data   (head_s),
        .count_nxt (count_nxt_s),
        .empty     (fifo_empty_s)
    );

    // Next-state logic; a dispatch also pops the FIFO head.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s && core_idle) begin
                    state_nxt_s = S_START;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (core_valid) begin
                    state_nxt_s = S_RESULT;
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESULT;
                end
            end
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_ERR;
        endcase
    end

    // State, datapath and outputs, all registered from next-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            timer_r    <= {TMR_W{1'b0}};
            core_a     <= {FP_W{1'b0}};
            core_b     <= {FP_W{1'b0}};
            res_z      <= {FP_W{1'b0}};
            res_flags  <= {FLAG_W{1'b0}};
            err        <= 1'b0;
            core_start <= 1'b0;
            core_ack   <= 1'b0;
            res_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                core_a <= head_s[2*FP_W-1:FP_W];
                core_b <= head_s[FP_W-1:0];
            end
            if (state_r == S_START) begin
                timer_r <= {TMR_W{1'b0}};
            end else if (state_r == S_WAIT) begin
                timer_r <= timer_r + TMR_W'(1'b1);
            end
            if ((state_r == S_WAIT) && core_valid) begin
                res_z     <= core_z;
                res_flags <= fp32_flags(core_z);
            end
            if (state_nxt_s == S_ERR) err <= 1'b1;
            core_start <= (state_nxt_s == S_START);
            core_ack   <= (state_nxt_s == S_WAIT);
            res_valid  <= (state_nxt_s == S_RESULT);
            in_ready   <= (count_nxt_s != CNT_W'(DEPTH)) && (state_nxt_s != S_ERR);
            busy       <= (count_nxt_s != {CNT_W{1'b0}}) || (state_nxt_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fpu_add_dispatcher.sv
// Bench for fpu_add_dispatcher: behavioural adder stub, vector table and a
// result scoreboard, plus directed sequences for queueing, stalls and errors.
module tb_fpu_add_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, core_start, core_ack, core_valid, core_idle;
    logic        res_valid, res_ready, err, busy;
    logic [31:0] in_a, in_b, core_a, core_b, core_z, res_z;
    logic [2:0]  res_flags;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [2:0]  f;
    } vec_t;

    vec_t tbl [6];
    vec_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        hang, hold_busy, stub_busy;
    logic [31:0] stub_a, stub_b;
    int          stub_cnt;
    int          start_count = 0;
    int          viol = 0;
    int          stab_err = 0;

    always #5 clk = ~clk;

    fpu_add_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_a(core_a),
        .core_b(core_b), .core_ack(core_ack), .core_z(core_z),
        .core_valid(core_valid), .core_idle(core_idle), .res_valid(res_valid),
        .res_ready(res_ready), .res_z(res_z), .res_flags(res_flags),
        .err(err), .busy(busy)
    );

    function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'hBF800000_3F800000: return 32'h00000000;
            64'h7F800000_7F800000: return 32'h7F800000;
            64'h7FC00000_3F800000: return 32'hFFC00000;
            default:               return a ^ b;
        endcase
    endfunction

    assign core_idle = !stub_busy && !hold_busy;

    // Adder stub: latches operands on start, answers after a few cycles while acked.
    always @(posedge clk) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            core_valid <= 1'b0;
            core_z     <= 32'h0;
            stub_cnt   <= 0;
            stub_a     <= 32'h0;
            stub_b     <= 32'h0;
        end else begin
            if (core_start) begin
                start_count <= start_count + 1;
                if (stub_busy) viol <= viol + 1;
            end
            if (!stub_busy) begin
                if (core_start) begin
                    stub_busy <= 1'b1;
                    stub_a    <= core_a;
                    stub_b    <= core_b;
                    stub_cnt  <= 3;
                end
            end else if (core_valid) begin
                core_valid <= 1'b0;
                stub_busy  <= 1'b0;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
            end else if (!hang && core_ack) begin
                core_valid <= 1'b1;
                core_z     <= add_lut(stub_a, stub_b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result monitor: every accepted result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && stub_busy && (core_a !== stub_a || core_b !== stub_b)) stab_err++;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got z=%h with no result pending", res_z);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check("res_z", res_z, e.z);
                check("res_flags", 32'(res_flags), 32'(e.f));
            end
        end
    end

    task automatic push_pair(input vec_t v);
        int k;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("push_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (k < 50) sb_q.push_back(v);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) break;
        end
        check("drain", 32'(k < 1000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_ack"}, 32'(core_ack), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_res_z"}, res_z, 32'd0);
        check({tag, "_flags"}, 32'(res_flags), 32'd0);
        check({tag, "_core_a"}, core_a, 32'd0);
    endtask

    initial begin
        int k;
        int s0;
        tbl[0] = '{a: 32'h3F800000, b: 32'h40000000, z: 32'h40400000, f: 3'b000};
        tbl[1] = '{a: 32'h3F800000, b: 32'h3F800000, z: 32'h40000000, f: 3'b000};
        tbl[2] = '{a: 32'h40000000, b: 32'h40000000, z: 32'h40800000, f: 3'b000};
        tbl[3] = '{a: 32'hBF800000, b: 32'h3F800000, z: 32'h00000000, f: 3'b001};
        tbl[4] = '{a: 32'h7F800000, b: 32'h7F800000, z: 32'h7F800000, f: 3'b010};
        tbl[5] = '{a: 32'h7FC00000, b: 32'h3F800000, z: 32'hFFC00000, f: 3'b100};

        rst = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
        res_ready = 1'b1; hang = 1'b0; hold_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Single op with latency and start-pulse count.
        s0 = start_count;
        push_pair(tbl[0]);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (core_start) break;
        end
        check("dispatch_latency", 32'(k), 32'd2);
        @(posedge clk); #1;
        drain();
        check("single_start_count", 32'(start_count - s0), 32'd1);

        // Table: each vector alone (includes zero, inf and NaN).
        for (int i = 0; i < 6; i++) begin
            push_pair(tbl[i]);
            drain();
        end

        // Queue fill with the core held busy.
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push_pair(tbl[i]);
        in_valid = 1'b1; in_a = tbl[0].a; in_b = tbl[0].b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
        end
        check("full_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; hold_busy = 1'b0;
        drain();

        // Backpressure: result must hold, no further dispatch.
        res_ready = 1'b0;
        s0 = start_count;
        push_pair(tbl[0]);
        push_pair(tbl[1]);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check("bp_res_valid_seen", 32'(k < 100), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_res_z", res_z, tbl[0].z);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_no_start", 32'(core_start), 32'd0);
        end
        check("bp_start_count", 32'(start_count - s0), 32'd1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain();
        check("bp_start_count_after", 32'(start_count - s0), 32'd2);

        // Reset while waiting on a hung core with three pairs queued.
        hang = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(tbl[i]);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_ack) break;
        end
        check("midop_in_wait", 32'(core_ack), 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        check_reset_outputs("midop");
        hang = 1'b0;
        s0 = start_count;
        repeat (50) @(posedge clk);
        check("midop_no_stale_start", 32'(start_count - s0), 32'd0);
        #1;
        push_pair(tbl[3]);
        drain();

        // Watchdog.
        hang = 1'b1;
        push_pair(tbl[0]);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (core_start) break;
        end
        check("wd_start_seen", 32'(core_start), 32'd1);
        s0 = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (err) break;
            if (core_ack) s0++;
        end
        check("wd_err_raised", 32'(err), 32'd1);
        check("wd_ack_cycles", 32'(s0), 32'(TIMEOUT));
        check("wd_in_ready", 32'(in_ready), 32'd0);
        check("wd_core_ack", 32'(core_ack), 32'd0);
        repeat (10) @(negedge clk);
        check("wd_err_sticky", 32'(err), 32'd1);
        check("wd_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        hang = 1'b0;
        @(negedge clk);
        check_reset_outputs("wd_reset");
        @(posedge clk); #1;
        push_pair(tbl[5]);
        drain();

        check("no_start_while_core_busy", 32'(viol), 32'd0);
        check("operands_stable", 32'(stab_err), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
